// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard inputs from the ID/EX/MEM stages and the pipeline control
// outputs. The controller sits on the slave side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  ex_load;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] id_rn;
  logic [REG_ADDR_W-1:0] id_rm;
  logic                  id_rn_used;
  logic                  id_rm_used;
  logic                  ex_branch_taken;
  logic                  mem_busy;

  logic                  pc_enable;
  logic                  ifid_enable;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  pipe_hold;
  logic [CNT_W-1:0]      stall_cycles;
  logic [1:0]            state_out;

  modport master (
    output ex_load, ex_rd, id_rn, id_rm, id_rn_used, id_rm_used,
           ex_branch_taken, mem_busy,
    input  pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_hold,
           stall_cycles, state_out
  );

  modport slave (
    input  ex_load, ex_rd, id_rn, id_rm, id_rn_used, id_rm_used,
           ex_branch_taken, mem_busy,
    output pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_hold,
           stall_cycles, state_out
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, memory-busy freeze with context save/restore, stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W        = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    MWAIT   = 2'd3
  } state_e;

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  state_e           saved_state_q, saved_state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       saved_cnt_q, saved_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  state_e     eff_state;
  logic [2:0] eff_cnt;
  logic       hazard;
  logic       pc_en, ifid_en, ifid_fl, idex_bub, hold;

  assign hazard = hz.ex_load &
                  ((hz.id_rn_used & (REG_ADDR_W'(hz.id_rn) == REG_ADDR_W'(hz.ex_rd))) |
                   (hz.id_rm_used & (REG_ADDR_W'(hz.id_rm) == REG_ADDR_W'(hz.ex_rd))));

  // On the cycle memory releases, the saved context drives this cycle's
  // decisions directly so a pending branch or hazard is acted on at once.
  always_comb begin
    eff_state = state_q;
    eff_cnt   = cnt_q;
    if (state_q == MWAIT && !hz.mem_busy) begin
      eff_state = saved_state_q;
      eff_cnt   = saved_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      saved_state_q <= RUN;
      saved_cnt_q   <= 3'd0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
      stall_q       <= stall_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    if (hz.mem_busy) begin
      if (state_q != MWAIT) begin
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
        state_d       = MWAIT;
      end
    end else begin
      state_d = eff_state;
      cnt_d   = eff_cnt;
      case (eff_state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d   = FL_RELOAD;
          end else if (hazard) begin
            state_d = (LOAD_STALL_CYCLES > 1) ? LDSTALL : RUN;
            cnt_d   = LD_RELOAD;
          end
        end
        LDSTALL: begin
          if (eff_cnt <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = eff_cnt - 3'd1;
          end
        end
        FLUSH: begin
          if (hz.ex_branch_taken) begin
            cnt_d = FL_RELOAD;
          end else if (eff_cnt <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = eff_cnt - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end

    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    hold     = 1'b0;
    if (!reset) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
    end else if (hz.mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      hold    = 1'b1;
    end else begin
      case (eff_state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            ifid_fl  = 1'b1;
            idex_bub = 1'b1;
          end else if (hazard) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_bub = 1'b1;
          end
        end
        LDSTALL: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_bub = 1'b1;
        end
        FLUSH: begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz.pc_enable    = pc_en;
  assign hz.ifid_enable  = ifid_en;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.idex_bubble  = idex_bub;
  assign hz.pipe_hold    = hold;
  assign hz.stall_cycles = stall_q;
  assign hz.state_out    = reset ? state_q : RUN;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, reset-abort and
// counter-saturation sequences, then random traffic against a cycle model.
module tb_pipeline_hazard_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) ifa ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4))  ifb ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .hz(ifa));
  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4))
    dut_b (.clk(clk), .reset(reset), .hz(ifb));

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] rd, rn, rm;
    logic       rnu, rmu, br, busy;
  } stim_t;

  // o = {pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_hold}
  typedef struct {
    stim_t      s;
    logic [4:0] o;
    logic [1:0] st;
    int         stall;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining bubble/flush cycles plus a frozen snapshot.
  int         p_ld[2]   = '{1, 3};
  int         p_fl[2]   = '{2, 3};
  int         p_max[2]  = '{65535, 15};
  int         ld_left[2], fl_left[2], sv_ld[2], sv_fl[2], stall_m[2];
  bit         frozen[2];
  logic [4:0] m_o[2];
  logic [1:0] m_st[2];
  int         m_stall[2];
  logic [4:0] a_o[2];
  logic [1:0] a_st[2];
  int         a_stall[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input int k, input stim_t s);
    bit hzd;
    hzd = s.ld && ((s.rnu && s.rn == s.rd) || (s.rmu && s.rm == s.rd));
    if (!s.rst) begin
      ld_left[k] = 0; fl_left[k] = 0; sv_ld[k] = 0; sv_fl[k] = 0;
      frozen[k] = 0; stall_m[k] = 0;
      m_o[k] = 5'b00110; m_st[k] = 2'd0; m_stall[k] = 0;
    end else begin
      m_stall[k] = stall_m[k];
      m_st[k] = frozen[k] ? 2'd3 : (ld_left[k] > 0) ? 2'd1 : (fl_left[k] > 0) ? 2'd2 : 2'd0;
      if (s.busy) begin
        m_o[k] = 5'b00001;
        if (!frozen[k]) begin
          sv_ld[k] = ld_left[k]; sv_fl[k] = fl_left[k]; frozen[k] = 1;
        end
      end else begin
        if (frozen[k]) begin
          ld_left[k] = sv_ld[k]; fl_left[k] = sv_fl[k]; frozen[k] = 0;
        end
        if (ld_left[k] > 0) begin
          m_o[k] = 5'b00010; ld_left[k]--;
        end else if (fl_left[k] > 0) begin
          m_o[k] = 5'b11110;
          fl_left[k] = s.br ? p_fl[k] - 1 : fl_left[k] - 1;
        end else if (s.br) begin
          m_o[k] = 5'b11110; fl_left[k] = p_fl[k] - 1;
        end else if (hzd) begin
          m_o[k] = 5'b00010; ld_left[k] = p_ld[k] - 1;
        end else begin
          m_o[k] = 5'b11000;
        end
      end
      if (!m_o[k][4] && stall_m[k] < p_max[k]) stall_m[k]++;
    end
  endtask

  task automatic sample();
    a_o[0]     = {ifa.pc_enable, ifa.ifid_enable, ifa.ifid_flush, ifa.idex_bubble, ifa.pipe_hold};
    a_st[0]    = ifa.state_out;
    a_stall[0] = int'(ifa.stall_cycles);
    a_o[1]     = {ifb.pc_enable, ifb.ifid_enable, ifb.ifid_flush, ifb.idex_bubble, ifb.pipe_hold};
    a_st[1]    = ifb.state_out;
    a_stall[1] = int'(ifb.stall_cycles);
  endtask

  task automatic cycle(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    reset = s.rst;
    ifa.ex_load = s.ld; ifa.ex_rd = s.rd; ifa.id_rn = s.rn; ifa.id_rm = s.rm;
    ifa.id_rn_used = s.rnu; ifa.id_rm_used = s.rmu;
    ifa.ex_branch_taken = s.br; ifa.mem_busy = s.busy;
    ifb.ex_load = s.ld; ifb.ex_rd = s.rd; ifb.id_rn = s.rn; ifb.id_rm = s.rm;
    ifb.id_rn_used = s.rnu; ifb.id_rm_used = s.rmu;
    ifb.ex_branch_taken = s.br; ifb.mem_busy = s.busy;
    @(negedge clk);
    sample();
    for (int k = 0; k < 2; k++) begin
      model_step(k, s);
      chk($sformatf("%s.dut%0d.outs", tag, k), 32'(a_o[k]), 32'(m_o[k]));
      chk($sformatf("%s.dut%0d.state", tag, k), 32'(a_st[k]), 32'(m_st[k]));
      chk($sformatf("%s.dut%0d.stall", tag, k), a_stall[k], m_stall[k]);
    end
    $display("[%s] rst=%0b ld=%0b rd=%0d rn=%0d/%0b rm=%0d/%0b br=%0b busy=%0b | a:o=%05b st=%0d cnt=%0d b:o=%05b st=%0d cnt=%0d",
             tag, s.rst, s.ld, s.rd, s.rn, s.rnu, s.rm, s.rmu, s.br, s.busy,
             a_o[0], a_st[0], a_stall[0], a_o[1], a_st[1], a_stall[1]);
  endtask

  function automatic stim_t st(logic rst, logic ld, logic [3:0] rd, logic [3:0] rn, logic [3:0] rm,
                               logic rnu, logic rmu, logic br, logic busy);
    stim_t s;
    s.rst = rst; s.ld = ld; s.rd = rd; s.rn = rn; s.rm = rm;
    s.rnu = rnu; s.rmu = rmu; s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic row_t mk(stim_t s, logic [4:0] o, logic [1:0] stt, int stall);
    row_t r;
    r.s = s; r.o = o; r.st = stt; r.stall = stall;
    return r;
  endfunction

  row_t  tbl[21];
  stim_t idle, brk, busy, haz;

  initial begin
    idle = st(1, 0, 0, 0, 0, 0, 0, 0, 0);
    brk  = st(1, 0, 0, 0, 0, 0, 0, 1, 0);
    busy = st(1, 0, 0, 0, 0, 0, 0, 0, 1);
    haz  = st(1, 1, 3, 3, 0, 1, 0, 0, 0);

    // Expectations for dut_a (LOAD_STALL_CYCLES=1, FLUSH_CYCLES=2)
    tbl[0]  = mk(st(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00110, 0, 0);
    tbl[1]  = mk(haz,  5'b00010, 0, 0);
    tbl[2]  = mk(idle, 5'b11000, 0, 1);
    tbl[3]  = mk(brk,  5'b11110, 0, 1);
    tbl[4]  = mk(idle, 5'b11110, 2, 1);
    tbl[5]  = mk(idle, 5'b11000, 0, 1);
    tbl[6]  = mk(brk,  5'b11110, 0, 1);
    tbl[7]  = mk(busy, 5'b00001, 2, 1);
    tbl[8]  = mk(busy, 5'b00001, 3, 2);
    tbl[9]  = mk(busy, 5'b00001, 3, 3);
    tbl[10] = mk(busy, 5'b00001, 3, 4);
    tbl[11] = mk(idle, 5'b11110, 3, 5);
    tbl[12] = mk(idle, 5'b11000, 0, 5);
    tbl[13] = mk(st(1, 1, 3, 3, 0, 1, 0, 1, 1), 5'b00001, 0, 5);
    tbl[14] = mk(st(1, 1, 3, 3, 0, 1, 0, 1, 0), 5'b11110, 3, 6);
    tbl[15] = mk(idle, 5'b11110, 2, 6);
    tbl[16] = mk(idle, 5'b11000, 0, 6);
    tbl[17] = mk(st(1, 1, 5, 0, 5, 0, 0, 0, 0), 5'b11000, 0, 6);
    tbl[18] = mk(st(1, 1, 5, 0, 5, 0, 1, 0, 0), 5'b00010, 0, 6);
    tbl[19] = mk(idle, 5'b11000, 0, 7);
    tbl[20] = mk(st(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00110, 0, 0);

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].s, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.outs", i), 32'(a_o[0]), 32'(tbl[i].o));
      chk($sformatf("tbl%0d.state", i), 32'(a_st[0]), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.stall", i), a_stall[0], tbl[i].stall);
    end

    // Reset asserted in the middle of a multi-cycle load stall on dut_b
    cycle(st(0, 0, 0, 0, 0, 0, 0, 0, 0), "rstab");
    cycle(haz, "rstab");
    chk("rstab.b.hazard_state", 32'(ifb.state_out), 32'd0);
    chk("rstab.b.hazard_pc", 32'(ifb.pc_enable), 32'd0);
    cycle(idle, "rstab");
    chk("rstab.b.ldstall_state", 32'(ifb.state_out), 32'd1);
    chk("rstab.b.ldstall_pc", 32'(ifb.pc_enable), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("rstab.b.abort_outs",
        32'({ifb.pc_enable, ifb.ifid_enable, ifb.ifid_flush, ifb.idex_bubble, ifb.pipe_hold}),
        32'(5'b00110));
    chk("rstab.b.abort_state", 32'(ifb.state_out), 32'd0);
    chk("rstab.b.abort_stall", 32'(ifb.stall_cycles), 32'd0);
    $display("[rstab] mid-stall reset: b:st=%0d pc=%0b cnt=%0d", ifb.state_out, ifb.pc_enable, ifb.stall_cycles);
    cycle(st(0, 0, 0, 0, 0, 0, 0, 0, 0), "rstab");
    cycle(idle, "rstab");
    chk("rstab.b.after_state", 32'(ifb.state_out), 32'd0);
    chk("rstab.b.after_pc", 32'(ifb.pc_enable), 32'd1);
    chk("rstab.b.after_stall", 32'(ifb.stall_cycles), 32'd0);

    // Saturation of the narrow counter on dut_b
    for (int i = 0; i < 20; i++) cycle(busy, "sat");
    cycle(idle, "sat");
    chk("sat.b.stall", 32'(ifb.stall_cycles), 32'd15);
    chk("sat.a.stall", 32'(ifa.stall_cycles), 32'd20);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      stim_t s;
      s.rst  = ($urandom_range(0, 99) != 0);
      s.ld   = ($urandom_range(0, 9) < 4);
      s.rd   = 4'($urandom_range(0, 3));
      s.rn   = 4'($urandom_range(0, 3));
      s.rm   = 4'($urandom_range(0, 3));
      s.rnu  = 1'($urandom_range(0, 1));
      s.rmu  = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 99) < 15);
      s.busy = ($urandom_range(0, 99) < 20);
      cycle(s, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
